// File: rtl/dht11_uart_report.sv
// dht11_uart_report
//   Takes each new checksum-good 32-bit DHT11 sample, converts the four bytes to
//   decimal ASCII and sends the 15-character line "H=DD.D T=DD.D\r\n" on an 8N1
//   UART transmit pin. Samples that arrive while a line is in flight are dropped
//   and counted.
//
// Ports
//   clk               system clock
//   rst_n             synchronous, active-low reset
//   dht11_data        {hum_int, hum_dec, temp_int, temp_dec}, stable while valid is high
//   dht11_data_valid  level from the reader (slower clock domain), high = checksum good
//   uart_tx           serial output, idle high
//   busy              high from the LOAD cycle through the last stop-bit cycle
//   drop_cnt          samples ignored because busy, saturates at 255

module dht11_uart_report #(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned BAUD     = 115_200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dht11_data,
    input  logic        dht11_data_valid,
    output logic        uart_tx,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_CHAR     = 4'd14;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StStop
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [3:0]       char_idx_q, char_idx_d;
    logic             tx_q, tx_d;
    logic [7:0]       drop_q;
    logic [31:0]      smp_q;

    logic             v_meta_q, v_s_q, v_s_dly_q;
    logic             new_sample;
    logic             baud_done;
    logic [7:0]       tx_char;

    // Decimal digits of the captured sample, loaded in StLoad
    logic [3:0] hum_tens_q, hum_ones_q, hum_dec_q;
    logic [3:0] tmp_tens_q, tmp_ones_q, tmp_dec_q;

    // ------------------------------------------------------------------
    // Conversion helpers
    // ------------------------------------------------------------------
    function automatic logic [6:0] sat99(input logic [7:0] v);
        return (v > 8'd99) ? 7'd99 : v[6:0];
    endfunction

    function automatic logic [3:0] sat9(input logic [7:0] v);
        return (v > 8'd9) ? 4'd9 : v[3:0];
    endfunction

    // Comparison ladder instead of a divider; v is already limited to 0..99
    function automatic logic [3:0] tens_of(input logic [6:0] v);
        logic [3:0] t;
        t = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (v >= 7'(i * 10)) t = 4'(i);
        end
        return t;
    endfunction

    function automatic logic [3:0] ones_of(input logic [6:0] v);
        return 4'(v - 7'(tens_of(v)) * 7'd10);
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizer and rising-edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_meta_q  <= 1'b0;
            v_s_q     <= 1'b0;
            v_s_dly_q <= 1'b0;
        end else begin
            v_meta_q  <= dht11_data_valid;
            v_s_q     <= v_meta_q;
            v_s_dly_q <= v_s_q;
        end
    end

    assign new_sample = v_s_q & ~v_s_dly_q;

    // ------------------------------------------------------------------
    // Sample capture and digit conversion
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp_q <= 32'h0;
        end else if (new_sample && state_q == StIdle) begin
            smp_q <= dht11_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hum_tens_q <= 4'd0;
            hum_ones_q <= 4'd0;
            hum_dec_q  <= 4'd0;
            tmp_tens_q <= 4'd0;
            tmp_ones_q <= 4'd0;
            tmp_dec_q  <= 4'd0;
        end else if (state_q == StLoad) begin
            hum_tens_q <= tens_of(sat99(smp_q[31:24]));
            hum_ones_q <= ones_of(sat99(smp_q[31:24]));
            hum_dec_q  <= sat9(smp_q[23:16]);
            tmp_tens_q <= tens_of(sat99(smp_q[15:8]));
            tmp_ones_q <= ones_of(sat99(smp_q[15:8]));
            tmp_dec_q  <= sat9(smp_q[7:0]);
        end
    end

    // ------------------------------------------------------------------
    // Drop counter: any rising edge seen outside StIdle is lost, including
    // one that lands on the final stop-bit cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else if (new_sample && state_q != StIdle && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    assign baud_done = (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            char_idx_q <= 4'd0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            char_idx_q <= char_idx_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;
        case (state_q)
            StIdle: begin
                if (new_sample) state_d = StLoad;
            end
            StLoad: begin
                state_d    = StStart;
                cnt_d      = '0;
                char_idx_d = 4'd0;
            end
            StStart: begin
                if (baud_done) begin
                    state_d   = StData;
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (baud_done) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (baud_done) begin
                    cnt_d = '0;
                    if (char_idx_q == LAST_CHAR) begin
                        state_d = StIdle;
                    end else begin
                        char_idx_d = char_idx_q + 4'd1;
                        state_d    = StStart;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Character for the next-cycle index. The digit registers are only stale
    // during StLoad, whose successor (start bit) does not look at the character.
    always_comb begin
        tx_char = 8'h0A;
        case (char_idx_d)
            4'd0:    tx_char = 8'h48;                    // 'H'
            4'd1:    tx_char = 8'h3D;                    // '='
            4'd2:    tx_char = ascii_digit(hum_tens_q);
            4'd3:    tx_char = ascii_digit(hum_ones_q);
            4'd4:    tx_char = 8'h2E;                    // '.'
            4'd5:    tx_char = ascii_digit(hum_dec_q);
            4'd6:    tx_char = 8'h20;                    // ' '
            4'd7:    tx_char = 8'h54;                    // 'T'
            4'd8:    tx_char = 8'h3D;                    // '='
            4'd9:    tx_char = ascii_digit(tmp_tens_q);
            4'd10:   tx_char = ascii_digit(tmp_ones_q);
            4'd11:   tx_char = 8'h2E;                    // '.'
            4'd12:   tx_char = ascii_digit(tmp_dec_q);
            4'd13:   tx_char = 8'h0D;
            default: tx_char = 8'h0A;
        endcase
    end

    // Output bit is derived from the next state so the pin comes straight off
    // a flop and lines up with the registered state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = tx_char[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    assign uart_tx  = tx_q;
    assign busy     = (state_q != StIdle);
    assign drop_cnt = drop_q;

endmodule
